// File: rtl/brightness_frame_ctrl_if.sv
// Pixel stream bundle (pixel/valid/last/ready) shared by the input and output
// sides of brightness_frame_ctrl.
interface brightness_frame_ctrl_if #(
  parameter int PIX_W = 8
) ();
  logic [PIX_W-1:0] pixel;
  logic             valid;
  logic             last;
  logic             ready;

  modport master (output pixel, output valid, output last, input ready);
  modport slave  (input pixel, input valid, input last, output ready);
endinterface

// File: rtl/brightness_frame_ctrl.sv
// Frame sequencer: buffers one frame (LOAD), replays it through a saturating
// brightness adjust (PROC), then pulses finish (DONE). Signed offset: BRIGHTNESS_SIGNED_EN.
module brightness_frame_ctrl #(
  parameter int PIX_W        = 8,
  parameter int FRAME_PIXELS = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [PIX_W-1:0]        bright,
  input  logic                    do_bright,
  brightness_frame_ctrl_if.slave  in_s,
  brightness_frame_ctrl_if.master out_m,
  output logic                    busy,
  output logic                    finish
);

  localparam int ADDR_W = $clog2(FRAME_PIXELS);
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PROC, S_DONE} state_e;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [PIX_W-1:0]   out_pixel_q, out_pixel_d;
  logic               busy_q, busy_d;
  logic               finish_q, finish_d;
  logic [CNT_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   frame_len_q, frame_len_d;
  logic [PIX_W-1:0]   bright_q, bright_d;
  logic               do_bright_q, do_bright_d;

  logic [PIX_W-1:0]   mem_q [FRAME_PIXELS];
  logic               in_fire;
  logic               out_fire;
  logic               mem_we;
  logic               rd_pending;
  logic [PIX_W-1:0]   rd_pixel;

  // Offset add computed one (unsigned) or two (signed) bits wider, then clamped.
  function automatic logic [PIX_W-1:0] adjust(input logic [PIX_W-1:0] px,
                                              input logic [PIX_W-1:0] off,
                                              input logic             en);
`ifdef BRIGHTNESS_SIGNED_EN
    logic signed [PIX_W+1:0] sum;
    sum = $signed({2'b00, px}) + $signed({{2{off[PIX_W-1]}}, off});
    if (!en)           return px;
    if (sum[PIX_W+1])  return '0;
    if (sum[PIX_W])    return '1;
    return sum[PIX_W-1:0];
`else
    logic [PIX_W:0] sum;
    sum = {1'b0, px} + {1'b0, off};
    if (!en)         return px;
    if (sum[PIX_W])  return '1;
    return sum[PIX_W-1:0];
`endif
  endfunction

  assign in_fire    = in_s.valid && in_ready_q;
  assign out_fire   = out_valid_q && out_m.ready;
  assign mem_we     = (state_q == S_LOAD) && in_fire;
  assign rd_pending = (rd_ptr_q != frame_len_q);
  // Asynchronous read lets the beat written on the last LOAD edge be read in the first PROC cycle.
  assign rd_pixel   = mem_q[rd_ptr_q[ADDR_W-1:0]];

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;
    busy_d      = busy_q;
    finish_d    = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    frame_len_d = frame_len_q;
    bright_d    = bright_q;
    do_bright_d = do_bright_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LOAD;
          in_ready_d  = 1'b1;
          busy_d      = 1'b1;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          frame_len_d = '0;
          bright_d    = bright;
          do_bright_d = do_bright;
        end
      end
      S_LOAD: begin
        if (in_fire) begin
          wr_ptr_d    = wr_ptr_q + 1'b1;
          frame_len_d = wr_ptr_q + 1'b1;
          if (in_s.last || (wr_ptr_q == CNT_W'(FRAME_PIXELS - 1))) begin
            state_d    = S_PROC;
            in_ready_d = 1'b0;
          end
        end
      end
      S_PROC: begin
        // Output register refills whenever it is empty or draining, giving one pixel per cycle.
        if (out_fire && !rd_pending) begin
          out_valid_d = 1'b0;
          state_d     = S_DONE;
          finish_d    = 1'b1;
        end else if ((!out_valid_q || out_m.ready) && rd_pending) begin
          out_valid_d = 1'b1;
          out_pixel_d = adjust(rd_pixel, bright_q, do_bright_q);
          rd_ptr_d    = rd_ptr_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_len_q <= '0;
      bright_q    <= '0;
      do_bright_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_len_q <= frame_len_d;
      bright_q    <= bright_d;
      do_bright_q <= do_bright_d;
    end
  end

  // Frame buffer is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= in_s.pixel;
    end
  end

  assign in_s.ready  = in_ready_q;
  assign out_m.valid = out_valid_q;
  assign out_m.pixel = out_pixel_q;
  assign out_m.last  = out_valid_q && !rd_pending;
  assign busy        = busy_q;
  assign finish      = finish_q;

endmodule

// File: tb/tb_brightness_frame_ctrl.sv
// Scoreboard bench for brightness_frame_ctrl: directed frames push expected
// pixels into a queue; an independent monitor pops and compares on each handshake.
module tb_brightness_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] bright;
  logic       do_bright;
  logic       busy;
  logic       finish;

  always #5 clk = ~clk;

  brightness_frame_ctrl_if #(.PIX_W(8)) in_if ();
  brightness_frame_ctrl_if #(.PIX_W(8)) out_if ();

  brightness_frame_ctrl #(.PIX_W(8), .FRAME_PIXELS(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bright    (bright),
    .do_bright (do_bright),
    .in_s      (in_if),
    .out_m     (out_if),
    .busy      (busy),
    .finish    (finish)
  );

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] px_a[64];
  logic [7:0] ex_a[64];
  bit         bp_en = 1'b0;
  bit         ignore_out = 1'b0;
  int         out_count = 0;
  int         finish_cnt = 0;
  bit         bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int         bp_k = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Downstream ready driver: always ready, or the 1,0,0,1 stall pattern.
  initial begin
    out_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        out_if.ready = bp_pat[bp_k % 4];
        bp_k++;
      end else begin
        out_if.ready = 1'b1;
      end
    end
  end

  // Monitor: output compare, stall stability, finish timing and width.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_px;
    bit         prev_last_hs;
    bit         prev_finish;
    bit         cur_last_hs;
    logic [7:0] e;
    prev_stall = 1'b0; prev_px = '0; prev_last_hs = 1'b0; prev_finish = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_stall = 1'b0; prev_last_hs = 1'b0; prev_finish = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", out_if.valid, 1);
          check("stall_pixel_held", out_if.pixel, prev_px);
        end
        if (finish) begin
          finish_cnt++;
          check("finish_after_last_hs", prev_last_hs, 1);
          check("finish_one_cycle", prev_finish, 0);
          check("finish_out_valid_low", out_if.valid, 0);
        end
        cur_last_hs = 1'b0;
        if (out_if.valid && out_if.ready) begin
          out_count++;
          if (!ignore_out) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_output actual=%0d required=no_output", out_if.pixel);
            end else begin
              e = exp_q.pop_front();
              check("out_pixel", out_if.pixel, e);
              cur_last_hs = (exp_q.size() == 0);
            end
          end
        end
        prev_stall   = out_if.valid && !out_if.ready;
        prev_px      = out_if.pixel;
        prev_last_hs = cur_last_hs;
        prev_finish  = finish;
      end
    end
  end

  // One full frame: start, n input beats, latency check, wait for finish.
  task automatic run_frame(input string tag, input logic [7:0] br, input logic db,
                           input int n, input bit use_last, input bit poke);
    int fc0;
    int c;
    fc0 = finish_cnt;
    out_count = 0;
    @(posedge clk); #1;
    start = 1'b1; bright = br; do_bright = db;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_in_ready_load"}, in_if.ready, 1);
    check({tag, "_busy_load"}, busy, 1);
    for (int i = 0; i < n; i++) begin
      in_if.pixel = px_a[i];
      in_if.valid = 1'b1;
      in_if.last  = use_last && (i == n - 1);
      exp_q.push_back(ex_a[i]);
      if (poke && i == 1) begin
        start = 1'b1; bright = 8'hFF; do_bright = ~db;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_if.valid = 1'b0; in_if.last = 1'b0; start = 1'b0; bright = 8'hAA;
    check({tag, "_out_valid_lat1"}, out_if.valid, 0);
    check({tag, "_in_ready_proc"}, in_if.ready, 0);
    check({tag, "_busy_proc"}, busy, 1);
    if (poke) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_out_valid_lat2"}, out_if.valid, 1);
    c = 0;
    while (c < 2000 && finish_cnt == fc0) begin
      @(posedge clk);
      c++;
    end
    #1;
    check({tag, "_finish_seen"}, finish_cnt - fc0, 1);
    check({tag, "_out_count"}, out_count, n);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fc0;
    rst_n = 1'b1;
    start = 1'b0; bright = '0; do_bright = 1'b0;
    in_if.pixel = '0; in_if.valid = 1'b0; in_if.last = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    check("rst_in_ready", in_if.ready, 0);
    check("rst_out_valid", out_if.valid, 0);
    check("rst_out_pixel", out_if.pixel, 0);
    check("rst_busy", busy, 0);
    check("rst_finish", finish, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Full 64-pixel frame: 100 + 60 = 160.
    for (int i = 0; i < 64; i++) begin px_a[i] = 8'd100; ex_a[i] = 8'd160; end
    run_frame("full", 8'd60, 1'b1, 64, 1'b0, 1'b0);

    // Saturation with in_last on the third pixel; start poked during LOAD and PROC.
    px_a[0] = 8'd200; px_a[1] = 8'd255; px_a[2] = 8'd0;
    ex_a[0] = 8'd255; ex_a[1] = 8'd255; ex_a[2] = 8'd60;
    run_frame("sat", 8'd60, 1'b1, 3, 1'b1, 1'b1);

    // Passthrough.
    px_a[0] = 8'd7; px_a[1] = 8'd8; px_a[2] = 8'd9;
    ex_a[0] = 8'd7; ex_a[1] = 8'd8; ex_a[2] = 8'd9;
    run_frame("pass", 8'd60, 1'b0, 3, 1'b1, 1'b0);

    // Backpressure: same results as without stalls.
    bp_en = 1'b1;
    px_a[0] = 8'd10; px_a[1] = 8'd20; px_a[2] = 8'd30; px_a[3] = 8'd40; px_a[4] = 8'd50;
    ex_a[0] = 8'd15; ex_a[1] = 8'd25; ex_a[2] = 8'd35; ex_a[3] = 8'd45; ex_a[4] = 8'd55;
    run_frame("bp", 8'd5, 1'b1, 5, 1'b1, 1'b0);
    px_a[0] = 8'd200; px_a[1] = 8'd255; px_a[2] = 8'd0;
    ex_a[0] = 8'd255; ex_a[1] = 8'd255; ex_a[2] = 8'd60;
    run_frame("bp_sat", 8'd60, 1'b1, 3, 1'b1, 1'b0);
    bp_en = 1'b0;

    // Single-pixel frame: 250 + 10 saturates.
    px_a[0] = 8'd250; ex_a[0] = 8'd255;
    run_frame("one", 8'd10, 1'b1, 1, 1'b1, 1'b0);

    // in_last on the 64th beat behaves as a full frame.
    for (int i = 0; i < 64; i++) begin px_a[i] = 8'(i * 3); ex_a[i] = 8'(i * 3); end
    run_frame("full_last", 8'd0, 1'b1, 64, 1'b1, 1'b0);

    // Offset 8'hC4: -60 when signed, 196 when unsigned.
    px_a[0] = 8'd100; px_a[1] = 8'd30;
`ifdef BRIGHTNESS_SIGNED_EN
    ex_a[0] = 8'd40;  ex_a[1] = 8'd0;
`else
    ex_a[0] = 8'd255; ex_a[1] = 8'd226;
`endif
    run_frame("offset_c4", 8'hC4, 1'b1, 2, 1'b1, 1'b0);

    // Reset in the middle of PROC abandons the frame without a finish.
    ignore_out = 1'b1;
    bp_en = 1'b1;
    fc0 = finish_cnt;
    @(posedge clk); #1;
    start = 1'b1; bright = 8'd1; do_bright = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_if.pixel = 8'(i + 1); in_if.valid = 1'b1; in_if.last = (i == 7);
      @(posedge clk); #1;
    end
    in_if.valid = 1'b0; in_if.last = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_if.valid, 0);
    check("midrst_out_pixel", out_if.pixel, 0);
    check("midrst_busy", busy, 0);
    check("midrst_finish", finish, 0);
    check("midrst_in_ready", in_if.ready, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_finish", finish_cnt - fc0, 0);
    check("midrst_idle_busy", busy, 0);
    ignore_out = 1'b0;
    bp_en = 1'b0;

    // Recovery frame after the abandoned one.
    px_a[0] = 8'd1; px_a[1] = 8'd2;
    ex_a[0] = 8'd1; ex_a[1] = 8'd2;
    run_frame("recover", 8'd99, 1'b0, 2, 1'b1, 1'b0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
